// File: rtl/tlb_assoc.sv
// Fully associative TLB with mixed 4K/2M/1G pages, ASID/global tagging,
// selective sfence.vma flush, a one-cycle registered lookup and saturating
// hit/miss counters. The page-table walker refills it through the update port.
module tlb_assoc #(
    parameter int ENTRIES    = 16,
    parameter int ASID_WIDTH = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  logic                  flush_valid_i,
    input  logic                  flush_vpn_en_i,
    input  logic                  flush_asid_en_i,
    input  logic [26:0]           flush_vpn_i,
    input  logic [ASID_WIDTH-1:0] flush_asid_i,
    input  logic                  access_valid_i,
    input  logic [26:0]           access_vpn_i,
    input  logic [ASID_WIDTH-1:0] access_asid_i,
    output logic                  access_valid_o,
    output logic                  access_miss_o,
    output logic [1:0]            access_level_o,
    output logic [7:0]            access_pte_o,
    output logic [43:0]           access_ppn_o,
    input  logic                  update_valid_i,
    output logic                  update_ready_o,
    input  logic [26:0]           update_vpn_i,
    input  logic [ASID_WIDTH-1:0] update_asid_i,
    input  logic [1:0]            update_level_i,
    input  logic [43:0]           update_ppn_i,
    input  logic [7:0]            update_pte_i,
    output logic [CNT_WIDTH-1:0]  hit_cnt_o,
    output logic [CNT_WIDTH-1:0]  miss_cnt_o
);
    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    // Entry storage: all tags are compared every cycle, so these are flops.
    logic [ENTRIES-1:0]    valid_reg;
    logic [ENTRIES-1:0]    glob_reg;
    logic [ASID_WIDTH-1:0] asid_reg  [ENTRIES];
    logic [26:0]           vpn_reg   [ENTRIES];
    logic [1:0]            level_reg [ENTRIES];
    logic [43:0]           ppn_reg   [ENTRIES];
    logic [7:0]            pte_reg   [ENTRIES];
    logic [IDX_W-1:0]      rr_ptr_reg;

    logic [ENTRIES-1:0] access_match;
    logic [ENTRIES-1:0] same_match;
    logic [ENTRIES-1:0] flush_kill;

    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic             same_any;
    logic [IDX_W-1:0] same_idx;
    logic             free_any;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] victim_idx;
    logic             advance_rr;
    logic [43:0]      hit_ppn;
    logic             do_write;

    // VPN bits above the page offset of the entry's level must agree.
    function automatic logic vpn_match(input logic [26:0] e_vpn,
                                       input logic [1:0]  e_level,
                                       input logic [26:0] vpn);
        return (vpn[26:18] == e_vpn[26:18]) &&
               ((e_level >= 2'd2) || (vpn[17:9] == e_vpn[17:9])) &&
               ((e_level >= 2'd1) || (vpn[8:0] == e_vpn[8:0]));
    endfunction

    assign update_ready_o = ~srst_i & ~flush_valid_i;
    assign do_write       = update_valid_i & update_ready_o & (update_level_i != 2'd3);

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_cmp
            assign access_match[gi] = valid_reg[gi] &
                                      (glob_reg[gi] | (asid_reg[gi] == access_asid_i)) &
                                      vpn_match(vpn_reg[gi], level_reg[gi], access_vpn_i);
            // Refill of an already-present translation reuses its slot.
            assign same_match[gi]   = valid_reg[gi] & (level_reg[gi] == update_level_i) &
                                      vpn_match(vpn_reg[gi], level_reg[gi], update_vpn_i) &
                                      ((asid_reg[gi] == update_asid_i) |
                                       (glob_reg[gi] & update_pte_i[5]));
            assign flush_kill[gi]   = (~flush_vpn_en_i |
                                       (valid_reg[gi] & vpn_match(vpn_reg[gi], level_reg[gi], flush_vpn_i))) &
                                      (~flush_asid_en_i |
                                       (~glob_reg[gi] & (asid_reg[gi] == flush_asid_i)));
        end
    endgenerate

    // Lowest-index priority encoders for lookup hit, refill reuse and free slot.
    always_comb begin
        hit      = |access_match;
        same_any = |same_match;
        free_any = ~&valid_reg;
        hit_idx  = '0;
        same_idx = '0;
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (access_match[i]) hit_idx  = IDX_W'(i);
            if (same_match[i])   same_idx = IDX_W'(i);
            if (!valid_reg[i])   free_idx = IDX_W'(i);
        end
        advance_rr = ~same_any & ~free_any;
        if (same_any)      victim_idx = same_idx;
        else if (free_any) victim_idx = free_idx;
        else               victim_idx = rr_ptr_reg;
    end

    // Superpages take their low PPN fields from the VPN.
    always_comb begin
        case (level_reg[hit_idx])
            2'd1:    hit_ppn = {ppn_reg[hit_idx][43:9], access_vpn_i[8:0]};
            2'd2:    hit_ppn = {ppn_reg[hit_idx][43:18], access_vpn_i[17:0]};
            default: hit_ppn = ppn_reg[hit_idx];
        endcase
    end

    // Entry state: flush beats refill; only a full TLB moves the round-robin pointer.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            valid_reg  <= '0;
            rr_ptr_reg <= '0;
        end else if (flush_valid_i) begin
            valid_reg <= valid_reg & ~flush_kill;
        end else if (do_write) begin
            valid_reg[victim_idx] <= 1'b1;
            glob_reg[victim_idx]  <= update_pte_i[5];
            asid_reg[victim_idx]  <= update_asid_i;
            vpn_reg[victim_idx]   <= update_vpn_i;
            level_reg[victim_idx] <= update_level_i;
            ppn_reg[victim_idx]   <= update_ppn_i;
            pte_reg[victim_idx]   <= update_pte_i;
            if (advance_rr) begin
                if (rr_ptr_reg == IDX_W'(ENTRIES - 1)) rr_ptr_reg <= '0;
                else                                   rr_ptr_reg <= rr_ptr_reg + IDX_W'(1);
            end
        end
    end

    // Registered lookup result; payload holds when no lookup is issued.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            access_valid_o <= 1'b0;
            access_miss_o  <= 1'b1;
            access_level_o <= '0;
            access_pte_o   <= '0;
            access_ppn_o   <= '0;
        end else begin
            access_valid_o <= access_valid_i;
            if (access_valid_i) begin
                access_miss_o  <= ~hit;
                access_level_o <= hit ? level_reg[hit_idx] : 2'd0;
                access_pte_o   <= hit ? pte_reg[hit_idx] : 8'd0;
                access_ppn_o   <= hit ? hit_ppn : 44'd0;
            end
        end
    end

    // Saturating counters advance together with the result they describe.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if (access_valid_i) begin
            if (hit) begin
                if (hit_cnt_o != {CNT_WIDTH{1'b1}}) hit_cnt_o <= hit_cnt_o + CNT_WIDTH'(1);
            end else begin
                if (miss_cnt_o != {CNT_WIDTH{1'b1}}) miss_cnt_o <= miss_cnt_o + CNT_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_tlb_assoc.sv
// Scoreboard bench for tlb_assoc: stimulus computes expected lookup results
// from a page-mask reference model and queues them; a monitor checks each
// result as the DUT presents it.
module tb_tlb_assoc;
    localparam int ENTRIES    = 16;
    localparam int ASID_WIDTH = 16;
    localparam int CNT_WIDTH  = 32;

    logic                  clk_i = 1'b0;
    logic                  srst_i;
    logic                  flush_valid_i, flush_vpn_en_i, flush_asid_en_i;
    logic [26:0]           flush_vpn_i;
    logic [ASID_WIDTH-1:0] flush_asid_i;
    logic                  access_valid_i;
    logic [26:0]           access_vpn_i;
    logic [ASID_WIDTH-1:0] access_asid_i;
    logic                  access_valid_o, access_miss_o;
    logic [1:0]            access_level_o;
    logic [7:0]            access_pte_o;
    logic [43:0]           access_ppn_o;
    logic                  update_valid_i, update_ready_o;
    logic [26:0]           update_vpn_i;
    logic [ASID_WIDTH-1:0] update_asid_i;
    logic [1:0]            update_level_i;
    logic [43:0]           update_ppn_i;
    logic [7:0]            update_pte_i;
    logic [CNT_WIDTH-1:0]  hit_cnt_o, miss_cnt_o;

    always #5 clk_i = ~clk_i;

    tlb_assoc #(.ENTRIES(ENTRIES), .ASID_WIDTH(ASID_WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk_i(clk_i), .srst_i(srst_i),
        .flush_valid_i(flush_valid_i), .flush_vpn_en_i(flush_vpn_en_i),
        .flush_asid_en_i(flush_asid_en_i), .flush_vpn_i(flush_vpn_i), .flush_asid_i(flush_asid_i),
        .access_valid_i(access_valid_i), .access_vpn_i(access_vpn_i), .access_asid_i(access_asid_i),
        .access_valid_o(access_valid_o), .access_miss_o(access_miss_o),
        .access_level_o(access_level_o), .access_pte_o(access_pte_o), .access_ppn_o(access_ppn_o),
        .update_valid_i(update_valid_i), .update_ready_o(update_ready_o),
        .update_vpn_i(update_vpn_i), .update_asid_i(update_asid_i), .update_level_i(update_level_i),
        .update_ppn_i(update_ppn_i), .update_pte_i(update_pte_i),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    typedef struct packed {
        logic        miss;
        logic [1:0]  level;
        logic [7:0]  pte;
        logic [43:0] ppn;
        logic [31:0] hc;
        logic [31:0] mc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    // Reference model: a table of translations plus the replacement pointer.
    bit          m_valid [ENTRIES];
    bit          m_g     [ENTRIES];
    logic [15:0] m_asid  [ENTRIES];
    logic [26:0] m_vpn   [ENTRIES];
    logic [1:0]  m_level [ENTRIES];
    logic [43:0] m_ppn   [ENTRIES];
    logic [7:0]  m_pte   [ENTRIES];
    int          m_ptr;
    logic [31:0] m_hits, m_misses;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Bits of the VPN that identify a page of the given size.
    function automatic logic [26:0] page_mask(input logic [1:0] lvl);
        logic [26:0] ones;
        ones = '1;
        return ones << (9 * lvl);
    endfunction

    function automatic bit covers(input int e, input logic [26:0] vpn);
        return m_valid[e] && (((vpn ^ m_vpn[e]) & page_mask(m_level[e])) == 27'd0);
    endfunction

    function automatic exp_t model_lookup(input logic [26:0] vpn, input logic [15:0] asid);
        exp_t r;
        r = '0;
        r.miss = 1'b1;
        for (int e = 0; e < ENTRIES; e++) begin
            if (r.miss && covers(e, vpn) && (m_g[e] || m_asid[e] == asid)) begin
                logic [43:0] low;
                low     = 44'((64'd1 << (9 * m_level[e])) - 64'd1);
                r.miss  = 1'b0;
                r.level = m_level[e];
                r.pte   = m_pte[e];
                r.ppn   = (m_ppn[e] & ~low) | ({17'd0, vpn} & low);
            end
        end
        return r;
    endfunction

    task automatic model_update();
        int slot;
        bit g;
        if (update_level_i == 2'd3) return;
        g = update_pte_i[5];
        slot = -1;
        for (int e = 0; e < ENTRIES; e++)
            if (slot < 0 && m_valid[e] && m_level[e] == update_level_i &&
                covers(e, update_vpn_i) && (m_asid[e] == update_asid_i || (m_g[e] && g)))
                slot = e;
        if (slot < 0)
            for (int e = 0; e < ENTRIES; e++)
                if (slot < 0 && !m_valid[e]) slot = e;
        if (slot < 0) begin
            slot  = m_ptr;
            m_ptr = (m_ptr + 1) % ENTRIES;
        end
        m_valid[slot] = 1; m_g[slot] = g; m_asid[slot] = update_asid_i;
        m_vpn[slot] = update_vpn_i; m_level[slot] = update_level_i;
        m_ppn[slot] = update_ppn_i; m_pte[slot] = update_pte_i;
    endtask

    task automatic model_flush();
        for (int e = 0; e < ENTRIES; e++) begin
            bit kill;
            kill = 1;
            if (flush_vpn_en_i && !covers(e, flush_vpn_i)) kill = 0;
            if (flush_asid_en_i && (m_g[e] || m_asid[e] != flush_asid_i)) kill = 0;
            if (kill) m_valid[e] = 0;
        end
    endtask

    task automatic idle_inputs();
        access_valid_i = 0; update_valid_i = 0;
        flush_valid_i = 0; flush_vpn_en_i = 0; flush_asid_en_i = 0;
    endtask

    task automatic set_access(input logic [26:0] vpn, input logic [15:0] asid);
        access_valid_i = 1; access_vpn_i = vpn; access_asid_i = asid;
    endtask

    task automatic set_update(input logic [26:0] vpn, input logic [15:0] asid, input logic [1:0] lvl,
                              input logic [43:0] ppn, input logic [7:0] pte);
        update_valid_i = 1; update_vpn_i = vpn; update_asid_i = asid;
        update_level_i = lvl; update_ppn_i = ppn; update_pte_i = pte;
    endtask

    task automatic set_flush(input bit ve, input bit ae, input logic [26:0] vpn, input logic [15:0] asid);
        flush_valid_i = 1; flush_vpn_en_i = ve; flush_asid_en_i = ae;
        flush_vpn_i = vpn; flush_asid_i = asid;
    endtask

    // One clock: queue the expected lookup, check ready, advance the model.
    task automatic step();
        exp_t e;
        #1;
        if (access_valid_i) begin
            e = model_lookup(access_vpn_i, access_asid_i);
            if (e.miss) begin
                if (m_misses != '1) m_misses++;
            end else begin
                if (m_hits != '1) m_hits++;
            end
            e.hc = m_hits;
            e.mc = m_misses;
            exp_q.push_back(e);
        end
        check("update_ready", 64'(update_ready_o), 64'(!flush_valid_i));
        if (flush_valid_i)       model_flush();
        else if (update_valid_i) model_update();
        @(posedge clk_i);
        #1;
        idle_inputs();
    endtask

    task automatic lookup(input logic [26:0] vpn, input logic [15:0] asid);
        set_access(vpn, asid);
        step();
    endtask

    task automatic refill(input logic [26:0] vpn, input logic [15:0] asid, input logic [1:0] lvl,
                          input logic [43:0] ppn, input logic [7:0] pte);
        set_update(vpn, asid, lvl, ppn, pte);
        step();
    endtask

    task automatic flush(input bit ve, input bit ae, input logic [26:0] vpn, input logic [15:0] asid);
        set_flush(ve, ae, vpn, asid);
        step();
    endtask

    // Monitor: every presented lookup result is matched against the queue head.
    always @(negedge clk_i) begin
        if (!srst_i && access_valid_o) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_result: got valid result, expected none queued");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                txn++;
                $display("txn %0d: miss=%0b level=%0d pte=%02h ppn=%011h hits=%0d misses=%0d",
                         txn, access_miss_o, access_level_o, access_pte_o, access_ppn_o,
                         hit_cnt_o, miss_cnt_o);
                check("miss",  64'(access_miss_o),  64'(e.miss));
                check("level", 64'(access_level_o), 64'(e.level));
                check("pte",   64'(access_pte_o),   64'(e.pte));
                check("ppn",   64'(access_ppn_o),   64'(e.ppn));
                check("hit_cnt",  64'(hit_cnt_o),  64'(e.hc));
                check("miss_cnt", 64'(miss_cnt_o), 64'(e.mc));
            end
        end
    end

    initial begin
        idle_inputs();
        flush_vpn_i = '0; flush_asid_i = '0; access_vpn_i = '0; access_asid_i = '0;
        update_vpn_i = '0; update_asid_i = '0; update_level_i = '0; update_ppn_i = '0; update_pte_i = '0;
        for (int e = 0; e < ENTRIES; e++) m_valid[e] = 0;
        m_ptr = 0; m_hits = 0; m_misses = 0;

        srst_i = 1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_ready",    64'(update_ready_o), 64'(0));
        check("rst_valid",    64'(access_valid_o), 64'(0));
        check("rst_miss",     64'(access_miss_o),  64'(1));
        check("rst_level",    64'(access_level_o), 64'(0));
        check("rst_pte",      64'(access_pte_o),   64'(0));
        check("rst_ppn",      64'(access_ppn_o),   64'(0));
        check("rst_hit_cnt",  64'(hit_cnt_o),      64'(0));
        check("rst_miss_cnt", 64'(miss_cnt_o),     64'(0));
        @(posedge clk_i);
        #1;
        srst_i = 0;

        // Cold miss, then 4K refill with ASID filtering.
        lookup(27'h0000123, 16'd1);
        refill(27'h0000123, 16'd1, 2'd0, 44'hABCDE, 8'hCF);
        lookup(27'h0000123, 16'd1);
        lookup(27'h0000123, 16'd2);

        // 2M superpage composition.
        refill(27'h0040200, 16'd1, 2'd1, 44'h0000400, 8'hCF);
        lookup(27'h0040255, 16'd1);

        // Fill-up and round-robin replacement.
        flush(0, 0, '0, '0);
        for (int i = 0; i < ENTRIES; i++) refill(27'h100 + 27'(i), 16'd1, 2'd0, 44'h1000 + 44'(i), 8'hCF);
        for (int i = 0; i < 3; i++) refill(27'h200 + 27'(i), 16'd1, 2'd0, 44'h2000 + 44'(i), 8'hCF);
        refill(27'h105, 16'd1, 2'd0, 44'h5555, 8'hC7);
        refill(27'h300, 16'd1, 2'd0, 44'h3000, 8'hCF);
        for (int i = 0; i < 6; i++) lookup(27'h100 + 27'(i), 16'd1);
        for (int i = 0; i < 3; i++) lookup(27'h200 + 27'(i), 16'd1);
        lookup(27'h300, 16'd1);

        // ASID flush spares global entries; full flush does not.
        flush(0, 0, '0, '0);
        refill(27'h0000400, 16'd1, 2'd0, 44'h400, 8'hEF);
        refill(27'h0000500, 16'd1, 2'd0, 44'h500, 8'hCF);
        flush(0, 1, '0, 16'd1);
        lookup(27'h0000400, 16'd1);
        lookup(27'h0000500, 16'd1);
        flush(0, 0, '0, '0);
        lookup(27'h0000400, 16'd1);
        lookup(27'h0000500, 16'd1);

        // Flush, refill and lookup in the same cycle.
        refill(27'h0000600, 16'd1, 2'd0, 44'h600, 8'hCF);
        set_flush(0, 0, '0, '0);
        set_update(27'h0000700, 16'd1, 2'd0, 44'h700, 8'hCF);
        set_access(27'h0000600, 16'd1);
        step();
        lookup(27'h0000600, 16'd1);
        lookup(27'h0000700, 16'd1);

        // Level-3 refill is accepted but installs nothing.
        refill(27'h0000800, 16'd1, 2'd3, 44'h800, 8'hCF);
        lookup(27'h0000800, 16'd1);

        // Randomized mix over a small address space to force hits and evictions.
        for (int n = 0; n < 600; n++) begin
            logic [26:0] v;
            v = {9'($urandom_range(0, 2)), 9'($urandom_range(0, 2)), 9'($urandom_range(0, 3))};
            if ($urandom_range(0, 99) < 4)
                set_flush(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), v, 16'($urandom_range(1, 2)));
            if ($urandom_range(0, 2) == 0)
                set_update({9'($urandom_range(0, 2)), 9'($urandom_range(0, 2)), 9'($urandom_range(0, 3))},
                           16'($urandom_range(1, 2)), 2'($urandom_range(0, 3)),
                           44'({$urandom, $urandom}), 8'($urandom));
            if ($urandom_range(0, 9) < 7)
                set_access(v, 16'($urandom_range(1, 2)));
            step();
        end

        repeat (3) @(posedge clk_i);
        #1;
        check("queue_drain", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
